// File: rtl/pattern_pkg.sv
// Shared types and defaults for the pattern serializer.
package pattern_pkg;

  typedef enum logic {IDLE, SHIFT} ser_state_t;

  localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/pattern_serializer.sv
// Double-buffered parallel-to-serial source: a shifter plus one pending word stream gap-free.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module pattern_serializer
  import pattern_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              serial_pattern,
  output logic              enable,
  output logic              word_done,
  output logic              busy
);

`ifdef SERIALIZER_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int              CNT_W    = $clog2(NBITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  ser_state_t        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              serial_q, serial_d;
  logic              enable_q, enable_d;
  logic              word_done_q, word_done_d;
  logic              accept_s;
  logic              load_s;
  logic [DATA_W-1:0] load_word_s;

`ifdef SERIALIZER_PARITY_EN
  localparam logic [CNT_W-1:0] PAR_CNT = CNT_W'(DATA_W);
  logic par_q, par_d;

  function automatic logic even_parity(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction
`endif

  assign accept_s = in_valid && !pend_vld_q;

  // Next-state, shifter, pending buffer and output-bit selection.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    bit_cnt_d   = bit_cnt_q;
    serial_d    = serial_q;
    enable_d    = enable_q;
    word_done_d = 1'b0;
    load_s      = 1'b0;
    load_word_s = in_data;
`ifdef SERIALIZER_PARITY_EN
    par_d       = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          load_s      = 1'b1;
          load_word_s = in_data;
        end else begin
          enable_d = 1'b0;
          serial_d = 1'b0;
        end
      end
      SHIFT: begin
        if (bit_cnt_q == LAST_CNT) begin
          // Pending word has priority; otherwise a same-cycle accept loads directly.
          if (pend_vld_q) begin
            load_s      = 1'b1;
            load_word_s = pend_q;
            pend_vld_d  = 1'b0;
          end else if (accept_s) begin
            load_s      = 1'b1;
            load_word_s = in_data;
          end else begin
            state_d   = IDLE;
            enable_d  = 1'b0;
            serial_d  = 1'b0;
            bit_cnt_d = {CNT_W{1'b0}};
          end
        end else begin
          bit_cnt_d   = bit_cnt_q + ONE_CNT;
          word_done_d = (bit_cnt_d == LAST_CNT);
`ifdef SERIALIZER_PARITY_EN
          if (bit_cnt_d == PAR_CNT) begin
            serial_d = par_q;
          end else
`endif
          if (LSB_FIRST) begin
            serial_d = shift_q[0];
            shift_d  = shift_q >> 1;
          end else begin
            serial_d = shift_q[DATA_W-1];
            shift_d  = shift_q << 1;
          end
          if (accept_s) begin
            pend_d     = in_data;
            pend_vld_d = 1'b1;
          end else begin
            pend_vld_d = pend_vld_q;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        enable_d   = 1'b0;
        serial_d   = 1'b0;
        bit_cnt_d  = {CNT_W{1'b0}};
        pend_vld_d = 1'b0;
      end
    endcase

    // The first bit goes straight to the output register; the shifter keeps the rest.
    if (load_s) begin
      state_d   = SHIFT;
      enable_d  = 1'b1;
      bit_cnt_d = {CNT_W{1'b0}};
`ifdef SERIALIZER_PARITY_EN
      par_d     = even_parity(load_word_s);
`endif
      if (LSB_FIRST) begin
        serial_d = load_word_s[0];
        shift_d  = load_word_s >> 1;
      end else begin
        serial_d = load_word_s[DATA_W-1];
        shift_d  = load_word_s << 1;
      end
    end else begin
      shift_d = shift_d;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q     <= IDLE;
      shift_q     <= {DATA_W{1'b0}};
      pend_q      <= {DATA_W{1'b0}};
      pend_vld_q  <= 1'b0;
      bit_cnt_q   <= {CNT_W{1'b0}};
      serial_q    <= 1'b0;
      enable_q    <= 1'b0;
      word_done_q <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      bit_cnt_q   <= bit_cnt_d;
      serial_q    <= serial_d;
      enable_q    <= enable_d;
      word_done_q <= word_done_d;
`ifdef SERIALIZER_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign in_ready       = !pend_vld_q;
  assign serial_pattern = serial_q;
  assign enable         = enable_q;
  assign word_done      = word_done_q;
  assign busy           = (state_q == SHIFT) || pend_vld_q;

endmodule
